systolic_pe_mc: RTL and testbench
=================================

// Module: systolic_pe_mc
// PURPOSE
// Multi-channel, runtime-precision systolic PE for the matrix-multiply arrays in conv and hidden layers.
// Computes a NumCh-wide dot product per beat: out_psum = sat(in_psum + sum_c a[c]*w[c]).
// Weights are double-buffered: the next tile loads through a shadow shift chain while the current tile computes.
// Activations, psums, weights and control are all forwarded registered, so arrays have no fan-out.
// PARAMETERS
// BitSize        8   activation width per channel, signed two's complement
// AccBitSize     16  partial-sum width, signed; must be >= BitSize
// M_W_BitSize    8   weight transport width per channel; the active weight is the low bits of this field
// NumCh          2   channels per PE (>=1)
// FixedPointPos  4   arithmetic right shift applied to products in W4/W8 modes
// PORTS
// clk        in   1                    rising-edge clock
// res_n      in   1                    asynchronous active-low reset
// en         in   1                    global advance; 0 = every register holds (array stall)
// w_mode     in   2                    weight precision: 0=W1, 1=W2, 2=W4, 3=W8; static within a tile
// in_valid   in   1                    in_a/in_psum beat valid
// in_a       in   NumCh*BitSize        packed activations, ch0 in the LSBs
// in_psum    in   AccBitSize           partial sum from the upstream PE
// in_w       in   NumCh*M_W_BitSize    packed weights for the shadow chain
// in_w_valid in   1                    in_w is valid; shift it into shadow
// in_swap    in   1                    commit shadow -> active (wavefront control)
// out_valid  out  1                    registered in_valid
// out_a      out  NumCh*BitSize        registered in_a (to the right neighbour)
// out_psum   out  AccBitSize           registered result (to the lower neighbour)
// out_w      out  NumCh*M_W_BitSize    registered in_w (chain forward)
// out_w_valid out 1                    registered in_w_valid
// out_swap   out  1                    registered in_swap
// out_ovf    out  1                    sticky saturation flag
// BEHAVIOUR
// - Reset (async assert, sync release): every output, shadow[] and active[] = 0. Active weights are undefined-free.
// - en=0: no register changes, including ovf; all inputs are ignored for that cycle.
// - Latency: exactly 1 cycle (with en=1) from every in_* to its out_* counterpart.
// - in_valid=1: out_psum, out_a update and out_valid<=1. in_valid=0: out_psum and out_a hold; out_valid<=0.
// - Weight decode per channel, from low bits of the lane, with products full-precision before the shift:
//   W1: bit0 0->-1, 1->+1. W2: signed [1:0] (-2..1). W4: signed [3:0]. W8: signed [7:0].
//   W4/W8 products are arithmetically shifted right by FixedPointPos (floor); W1/W2 are not shifted.
// - Sum = in_psum + sum of the shifted products, computed at AccBitSize+clog2(NumCh+1)+BitSize+8 width.
//   Then saturate to [-2^(AccBitSize-1), 2^(AccBitSize-1)-1].
//   Saturation sets out_ovf (sticky). out_ovf clears only on reset or on an in_swap beat (new tile).
// - Products use active[] as it was at the start of the cycle. A swap in cycle t affects beats from t+1 on.
// - in_w_valid=1: shadow <= in_w. Forward chain: out_w <= in_w and out_w_valid <= in_w_valid every en cycle.
// - in_swap=1: active <= shadow (the value before any same-cycle write). out_swap <= in_swap every en cycle.
// - in_swap and in_w_valid together: active takes the old shadow, and shadow takes in_w.
// - in_swap and in_valid together: the beat computes with the old active; the ovf clear takes priority over a same-beat set.
// - w_mode change mid-tile: illegal; no check is made, and results are undefined.
// STRUCTURE
// - systolic_pkg (shared): w_mode_t enum {W1,W2,W4,W8}; function sat_acc(); clog2 helper constants.
// - Sub-module pe_mac_lane (x NumCh, generate loop): combinational decode + multiply + shift for one channel,
//   producing a signed product sized to the worst case (W8).
// - The top level holds the shadow/active regs, the adder tree, saturation and the forwarding regs.
// TESTING (defaults BitSize=8, AccBitSize=16, NumCh=2, FixedPointPos=4)
// - Reset mid-tile: assert res_n low asynchronously between edges -> all outputs 0 immediately; active=0 then gives psum=in_psum.
// - W8: load w=(0x20,0xF0) + swap, a=(16,3), psum=100 -> next cycle out_psum = 100 + (16*32>>4) + (3*-16>>4) = 129.
// - W1: w=(0b0,0b1), a=(5,-7), psum=0 -> out_psum = -5 + -7 = -12. W2 w=(2'b10,2'b01), a=(3,3) -> -6+3 = -3.
// - Saturation: W8 w=(127,127), a=(127,127), psum=32000 -> out_psum=32767, out_ovf=1. A later swap beat clears ovf.
// - Double buffer: stream beats under weights A while shifting B into shadow; swap on beat k.
//   Beats <=k use A, beats >k use B; swap+w_valid in the same cycle -> active=old shadow.
// - Stall: en=0 for 3 cycles mid-stream -> all outputs frozen; the resumed sequence equals the unstalled golden result.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic PE slice
package systolic_pkg;
  typedef enum logic [1:0] {W1, W2, W4, W8} w_mode_t;
  localparam int WDEC_W = 8;
  localparam int SAT_W = 64;
  function automatic int sum_w(input int acc_w, input int nch, input int bit_w);
    return acc_w + $clog2(nch + 1) + bit_w + WDEC_W;
  endfunction
  function automatic logic signed [SAT_W-1:0] sat_acc(input logic signed [SAT_W-1:0] v, input int acc_w);
    logic signed [SAT_W-1:0] hi;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    return v > hi ? hi : v < ~hi ? ~hi : v;
  endfunction
endpackage

// File: rtl/pe_mac_lane.sv
// pe_mac_lane: one channel of weight decode, signed multiply and fixed-point shift
module pe_mac_lane
  import systolic_pkg::*;
#(
  parameter int BitSize = 8,
  parameter int M_W_BitSize = 8,
  parameter int FixedPointPos = 4
) (
  input  w_mode_t                            w_mode,
  input  logic signed [BitSize-1:0]          a,
  input  logic        [M_W_BitSize-1:0]      w,
  output logic signed [BitSize+WDEC_W-1:0]   prod
);
  localparam int PW = BitSize + WDEC_W;
  logic signed [WDEC_W-1:0] wd;
  logic signed [PW-1:0] full;
  always_comb begin
    wd = w_mode == W1 ? (w[0] ? 8'sd1 : -8'sd1) :
         w_mode == W2 ? 8'(signed'(w[1:0])) :
         w_mode == W4 ? 8'(signed'(w[3:0])) : signed'(w[7:0]);
    full = PW'(a) * PW'(wd);
    prod = (w_mode == W4 || w_mode == W8) ? full >>> FixedPointPos : full;
  end
endmodule

// File: rtl/systolic_pe_mc.sv
// systolic_pe_mc: multi-channel runtime-precision systolic PE with double-buffered weights
// and fully registered forwarding of activations, psums, weights and control.
module systolic_pe_mc
  import systolic_pkg::*;
#(
  parameter int BitSize = 8,
  parameter int AccBitSize = 16,
  parameter int M_W_BitSize = 8,
  parameter int NumCh = 2,
  parameter int FixedPointPos = 4
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           en,
  input  logic [1:0]                     w_mode,
  input  logic                           in_valid,
  input  logic [NumCh*BitSize-1:0]       in_a,
  input  logic [AccBitSize-1:0]          in_psum,
  input  logic [NumCh*M_W_BitSize-1:0]   in_w,
  input  logic                           in_w_valid,
  input  logic                           in_swap,
  output logic                           out_valid,
  output logic [NumCh*BitSize-1:0]       out_a,
  output logic [AccBitSize-1:0]          out_psum,
  output logic [NumCh*M_W_BitSize-1:0]   out_w,
  output logic                           out_w_valid,
  output logic                           out_swap,
  output logic                           out_ovf
);
  localparam int PW = BitSize + WDEC_W;
  localparam int SW = sum_w(AccBitSize, NumCh, BitSize);
  logic [NumCh*M_W_BitSize-1:0] shadow, active;
  logic signed [PW-1:0] prod [NumCh];
  logic signed [SW-1:0] sum;
  logic signed [SAT_W-1:0] sum_x, sat;
  logic [AccBitSize-1:0] psum_n;
  logic hit;
  genvar i;
  generate
    for (i = 0; i < NumCh; i++) begin : g_lane
      pe_mac_lane #(
        .BitSize(BitSize),
        .M_W_BitSize(M_W_BitSize),
        .FixedPointPos(FixedPointPos)
      ) u_lane (
        .w_mode(w_mode_t'(w_mode)),
        .a(in_a[i*BitSize +: BitSize]),
        .w(active[i*M_W_BitSize +: M_W_BitSize]),
        .prod(prod[i])
      );
    end
  endgenerate
  always_comb begin
    sum = SW'(signed'(in_psum));
    for (int c = 0; c < NumCh; c++) sum = sum + SW'(prod[c]);
    sum_x = SAT_W'(sum);
    sat = sat_acc(sum_x, AccBitSize);
    hit = sat != sum_x;
    psum_n = AccBitSize'(sat);
  end
  // swap reads shadow before the same-cycle load, and a swap beat's ovf clear beats a set
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shadow <= '0;
      active <= '0;
      out_valid <= 1'b0;
      out_a <= '0;
      out_psum <= '0;
      out_w <= '0;
      out_w_valid <= 1'b0;
      out_swap <= 1'b0;
      out_ovf <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_w <= in_w;
      out_w_valid <= in_w_valid;
      out_swap <= in_swap;
      if (in_valid) begin
        out_a <= in_a;
        out_psum <= psum_n;
      end
      if (in_w_valid) shadow <= in_w;
      if (in_swap) active <= shadow;
      out_ovf <= in_swap ? 1'b0 : (in_valid && hit) ? 1'b1 : out_ovf;
    end
  end
endmodule

// File: tb/tb_systolic_pe_mc.sv
// tb_systolic_pe_mc: directed spec cases plus randomized streams against an integer reference model
module tb_systolic_pe_mc;
  localparam int FPP = 4;
  logic clk = 0, res_n = 0, en = 0, in_valid = 0, in_w_valid = 0, in_swap = 0;
  logic [1:0] w_mode = 0;
  logic [15:0] in_a = 0, in_psum = 0, in_w = 0;
  logic out_valid, out_w_valid, out_swap, out_ovf;
  logic [15:0] out_a, out_psum, out_w;
  int n_cmp = 0, n_bad = 0;
  int sh[2], ac[2];
  logic e_valid, e_wv, e_swap, e_ovf;
  logic [15:0] e_a, e_psum, e_w;

  systolic_pe_mc #(
    .BitSize(8), .AccBitSize(16), .M_W_BitSize(8), .NumCh(2), .FixedPointPos(FPP)
  ) dut (
    .clk(clk), .res_n(res_n), .en(en), .w_mode(w_mode),
    .in_valid(in_valid), .in_a(in_a), .in_psum(in_psum), .in_w(in_w),
    .in_w_valid(in_w_valid), .in_swap(in_swap),
    .out_valid(out_valid), .out_a(out_a), .out_psum(out_psum), .out_w(out_w),
    .out_w_valid(out_w_valid), .out_swap(out_swap), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // weight value from the raw lane byte, then product with optional floor shift
  function automatic int lane(input int a, input int w, input int mode);
    int d, p;
    d = mode == 0 ? ((w & 1) != 0 ? 1 : -1) :
        mode == 1 ? (((w & 3) ^ 2) - 2) :
        mode == 2 ? (((w & 15) ^ 8) - 8) : (((w & 255) ^ 128) - 128);
    p = a * d;
    return mode >= 2 ? p >>> FPP : p;
  endfunction

  task automatic model_clear();
    {e_valid, e_wv, e_swap, e_ovf} = '0;
    {e_a, e_psum, e_w} = '0;
    sh = '{0, 0};
    ac = '{0, 0};
  endtask

  task automatic cmp_all(input string p);
    check({p, "valid"}, out_valid, e_valid);
    check({p, "a"}, out_a, e_a);
    check({p, "psum"}, out_psum, e_psum);
    check({p, "w"}, out_w, e_w);
    check({p, "wvalid"}, out_w_valid, e_wv);
    check({p, "swap"}, out_swap, e_swap);
    check({p, "ovf"}, out_ovf, e_ovf);
  endtask

  task automatic cyc();
    int s;
    bit hit;
    hit = 0;
    @(posedge clk);
    if (en) begin
      if (in_valid) begin
        s = int'($signed(in_psum));
        for (int c = 0; c < 2; c++) s += lane(int'($signed(in_a[c*8 +: 8])), ac[c], int'(w_mode));
        hit = s > 32767 || s < -32768;
        e_psum = 16'(s > 32767 ? 32767 : s < -32768 ? -32768 : s);
        e_a = in_a;
      end
      e_ovf = in_swap ? 1'b0 : hit ? 1'b1 : e_ovf;
      e_valid = in_valid;
      e_w = in_w;
      e_wv = in_w_valid;
      e_swap = in_swap;
      if (in_swap) ac = sh;
      if (in_w_valid) for (int c = 0; c < 2; c++) sh[c] = int'(in_w[c*8 +: 8]);
    end
    #1 cmp_all("cyc_");
  endtask

  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] p,
                       input bit wv, input logic [15:0] w, input bit sw);
    en = 1;
    in_valid = v;
    in_a = a;
    in_psum = p;
    in_w_valid = wv;
    in_w = w;
    in_swap = sw;
    cyc();
  endtask

  task automatic do_reset();
    #2 res_n = 0;
    model_clear();
    #1 cmp_all("rst_");
    @(negedge clk);
    res_n = 1;
  endtask

  initial begin
    do_reset();
    w_mode = 3;
    drive(0, 0, 0, 1, 16'hF020, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 16'h0310, 16'd100, 0, 0, 0);
    check("w8_psum", out_psum, 16'd129);
    w_mode = 0;
    drive(0, 0, 0, 1, 16'h0100, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 16'hF905, 16'd0, 0, 0, 0);
    check("w1_psum", out_psum, 16'hFFF4);
    w_mode = 1;
    drive(0, 0, 0, 1, 16'h0102, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 16'h0303, 16'd0, 0, 0, 0);
    check("w2_psum", out_psum, 16'hFFFD);
    w_mode = 3;
    drive(0, 0, 0, 1, 16'h7F7F, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 16'h7F7F, 16'd32000, 0, 0, 0);
    check("sat_psum", out_psum, 16'h7FFF);
    check("sat_ovf", out_ovf, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("ovf_sticky", out_ovf, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("ovf_clear", out_ovf, 0);
    drive(1, 16'h0101, 16'd0, 1, 16'h1010, 0);
    drive(1, 16'h0101, 16'd0, 0, 0, 1);
    check("dbuf_k", out_psum, 16'd14);
    drive(1, 16'h0101, 16'd0, 0, 0, 0);
    check("dbuf_k1", out_psum, 16'd2);
    drive(0, 0, 0, 1, 16'h2020, 0);
    drive(0, 0, 0, 1, 16'h4040, 1);
    drive(1, 16'h0101, 16'd0, 0, 0, 0);
    check("swap_wv_old", out_psum, 16'd4);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 16'h0202, 16'd0, 0, 0, 0);
    check("swap_wv_new", out_psum, 16'd16);
    en = 0;
    repeat (3) begin
      in_valid = 1;
      in_a = 16'($urandom);
      in_psum = 16'($urandom);
      in_w = 16'($urandom);
      in_w_valid = 1;
      in_swap = 1;
      cyc();
    end
    check("stall_psum", out_psum, 16'd16);
    check("stall_swap", out_swap, 0);
    drive(1, 16'h0101, 16'd0, 0, 0, 0);
    check("resume_psum", out_psum, 16'd8);
    do_reset();
    drive(1, 16'($urandom), 16'd1234, 0, 0, 0);
    check("rst_active0", out_psum, 16'd1234);
    for (int m = 0; m < 4; m++) begin
      do_reset();
      w_mode = 2'(m);
      repeat (250) begin
        en = ($urandom % 6) != 0;
        in_valid = 1'($urandom);
        in_a = 16'($urandom);
        in_psum = 16'($urandom);
        in_w = 16'($urandom);
        in_w_valid = 1'($urandom);
        in_swap = ($urandom % 5) == 0;
        cyc();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
